zombie_spawner: RTL and testbench

- Consumer of the free-running 8-bit LFSR random stream (RANGEN output Rand_num).
- Turns random bytes into paced zombie spawn requests: a random inter-spawn delay, a random x position and a random zombie type.
- Sits between the random generator and the zombie object manager.
- Presents each request on a valid/ack handshake and tracks the live-zombie count so the population never exceeds a cap.

---
 rtl/zombie_spawner_pkg.sv | 25 ++
 rtl/zombie_spawner_if.sv | 25 ++
 rtl/zombie_spawner_delay.sv | 35 +++
 rtl/zombie_spawner.sv | 101 ++++++++++
 tb/tb_zombie_spawner.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/zombie_spawner_pkg.sv
// Shared types and constants for the zombie spawn path.
// Used by the spawner FSM, its delay timer and the bench.
package zc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    DRAW_X,
    DRAW_T,
    REQ
  } spawn_state_t;

  localparam int SCREEN_W = 640;
  localparam int ZOMBIE_W = 32;

  typedef logic [1:0] zombie_type_t;

  function automatic logic [9:0] scale_x(
    input logic [7:0] r,
    input int         margin
  );
    return {1'b0, r, 1'b0} + 10'(margin);
  endfunction

endpackage

// File: rtl/zombie_spawner_if.sv
// Spawn request handshake between spawner and object manager.
// Request fields stay stable while Spawn_valid is high.
interface zombie_spawner_if;
  import zc_pkg::*;

  logic         Spawn_valid;
  logic [9:0]   Spawn_x;
  zombie_type_t Spawn_type;
  logic         Spawn_ack;

  modport master (
    output Spawn_valid,
    output Spawn_x,
    output Spawn_type,
    input  Spawn_ack
  );

  modport slave (
    input  Spawn_valid,
    input  Spawn_x,
    input  Spawn_type,
    output Spawn_ack
  );

endinterface

// File: rtl/zombie_spawner_delay.sv
// Inter-spawn frame delay counter with load priority.
// Reports when the counter's next value will be zero.
module spawn_delay_timer (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [6:0] load_val_i,
  input  logic       tick_i,
  input  logic       en_i,
  output logic       zero_next_o
);

  logic [6:0] cnt_q;
  logic [6:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (tick_i && en_i && cnt_q != 7'd0) begin
      cnt_d = cnt_q - 7'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 7'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_next_o = (cnt_d == 7'd0);

endmodule

// File: rtl/zombie_spawner.sv
// Paced zombie spawn request generator fed by the LFSR byte stream.
// Draws delay, x and type from successive random bytes; caps population.
module zombie_spawner
  import zc_pkg::*;
#(
  parameter int MAX_ZOMBIES = 8,
  parameter int MIN_DELAY   = 16,
  parameter int X_MARGIN    = 64
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Enable,
  input  logic              Frame_tick,
  input  logic [7:0]        Rand_num,
  input  logic              Zombie_died,
  output logic [3:0]        Alive_cnt,
  zombie_spawner_if.master  spawn
);

  spawn_state_t state_q, state_d;
  logic         valid_q, valid_d;
  logic [9:0]   x_q, x_d;
  zombie_type_t type_q, type_d;
  logic [3:0]   alive_q, alive_d;

  logic       accept;
  logic       load;
  logic [6:0] load_val;
  logic       zero_next;

  assign accept   = (state_q == REQ) && spawn.Spawn_ack;
  assign load     = ((state_q == IDLE) && Enable) || accept;
  assign load_val = 7'(MIN_DELAY) + 7'(Rand_num[5:0]);

  spawn_delay_timer u_timer (
    .clk_i       (Clk),
    .rst_i       (Reset),
    .load_i      (load),
    .load_val_i  (load_val),
    .tick_i      (Frame_tick),
    .en_i        (Enable),
    .zero_next_o (zero_next)
  );

  always_comb begin
    alive_d = alive_q;
    if (accept && !Zombie_died) begin
      alive_d = alive_q + 4'd1;
    end else if (!accept && Zombie_died && alive_q != 4'd0) begin
      alive_d = alive_q - 4'd1;
    end
  end

  // Look ahead on counter and population so DRAW_X starts the cycle
  // the delay expires or a slot frees up.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (Enable) state_d = WAIT;
      WAIT: begin
        if (zero_next && alive_d < 4'(MAX_ZOMBIES)) begin
          state_d = DRAW_X;
        end
      end
      DRAW_X: state_d = DRAW_T;
      DRAW_T: state_d = REQ;
      REQ:    if (spawn.Spawn_ack) state_d = WAIT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    x_d     = x_q;
    type_d  = type_q;
    valid_d = (state_d == REQ);
    if (state_q == DRAW_X) x_d = scale_x(Rand_num, X_MARGIN);
    if (state_q == DRAW_T) type_d = Rand_num[1:0];
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      x_q     <= 10'd0;
      type_q  <= 2'd0;
      alive_q <= 4'd0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      x_q     <= x_d;
      type_q  <= type_d;
      alive_q <= alive_d;
    end
  end

  assign spawn.Spawn_valid = valid_q;
  assign spawn.Spawn_x     = x_q;
  assign spawn.Spawn_type  = type_q;
  assign Alive_cnt         = alive_q;

endmodule

// File: tb/tb_zombie_spawner.sv
// Directed bench for zombie_spawner: timing, hold, cap, enable.
// Expected values are hand-computed constants.
module tb_zombie_spawner;
  import zc_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Enable;
  logic       Frame_tick;
  logic [7:0] Rand_num;
  logic       Zombie_died;
  logic [3:0] Alive_cnt;

  int total = 0;
  int bad   = 0;

  zombie_spawner_if sif ();

  zombie_spawner dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Enable      (Enable),
    .Frame_tick  (Frame_tick),
    .Rand_num    (Rand_num),
    .Zombie_died (Zombie_died),
    .Alive_cnt   (Alive_cnt),
    .spawn       (sif)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int st();
    return int'(dut.state_q);
  endfunction

  function automatic int cnt();
    return int'(dut.u_timer.cnt_q);
  endfunction

  task automatic run_to_req(input string tag);
    bit hit;
    hit = 1'b0;
    Frame_tick = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (st() == int'(DRAW_X)) begin
        hit = 1'b1;
        break;
      end
    end
    Frame_tick = 1'b0;
    chk({tag, "_drawx"}, int'(hit), 1);
    step();
    step();
    chk({tag, "_valid"}, int'(sif.Spawn_valid), 1);
  endtask

  task automatic ack(input logic died);
    sif.Spawn_ack = 1'b1;
    Zombie_died   = died;
    Rand_num      = 8'h00;
    step();
    sif.Spawn_ack = 1'b0;
    Zombie_died   = 1'b0;
  endtask

  initial begin
    Reset         = 1'b1;
    Enable        = 1'b1;
    Frame_tick    = 1'b0;
    Rand_num      = 8'hFF;
    Zombie_died   = 1'b0;
    sif.Spawn_ack = 1'b0;
    repeat (3) step();
    chk("rst_valid", int'(sif.Spawn_valid), 0);
    chk("rst_x", int'(sif.Spawn_x), 0);
    chk("rst_type", int'(sif.Spawn_type), 0);
    chk("rst_alive", int'(Alive_cnt), 0);
    chk("rst_state", st(), int'(IDLE));
    chk("rst_cnt", cnt(), 0);

    Reset    = 1'b0;
    Rand_num = 8'h05;
    step();
    chk("load_state", st(), int'(WAIT));
    chk("load_cnt", cnt(), 21);

    Zombie_died = 1'b1;
    step();
    Zombie_died = 1'b0;
    chk("died_at0", int'(Alive_cnt), 0);
    chk("died_cnt", cnt(), 21);

    Frame_tick = 1'b1;
    repeat (20) step();
    chk("tick20_cnt", cnt(), 1);
    chk("tick20_state", st(), int'(WAIT));
    Rand_num = 8'h80;
    step();
    Frame_tick = 1'b0;
    chk("tick21_cnt", cnt(), 0);
    chk("tick21_state", st(), int'(DRAW_X));
    chk("tick21_valid", int'(sif.Spawn_valid), 0);
    step();
    chk("dx_state", st(), int'(DRAW_T));
    chk("dx_x", int'(sif.Spawn_x), 320);
    chk("dx_valid", int'(sif.Spawn_valid), 0);
    Rand_num = 8'h03;
    step();
    chk("dt_valid", int'(sif.Spawn_valid), 1);
    chk("dt_type", int'(sif.Spawn_type), 3);

    for (int i = 0; i < 10; i++) begin
      Rand_num = 8'(i * 37 + 11);
      step();
      chk("hold_valid", int'(sif.Spawn_valid), 1);
      chk("hold_x", int'(sif.Spawn_x), 320);
      chk("hold_type", int'(sif.Spawn_type), 3);
    end

    sif.Spawn_ack = 1'b1;
    Rand_num      = 8'h05;
    step();
    sif.Spawn_ack = 1'b0;
    chk("ack_valid", int'(sif.Spawn_valid), 0);
    chk("ack_alive", int'(Alive_cnt), 1);
    chk("ack_state", st(), int'(WAIT));
    chk("ack_cnt", cnt(), 21);

    for (int i = 0; i < 3; i++) begin
      run_to_req("sp_a");
      ack(1'b0);
    end
    chk("alive4", int'(Alive_cnt), 4);
    run_to_req("sp_b");
    ack(1'b1);
    chk("ack_died", int'(Alive_cnt), 4);
    for (int i = 0; i < 4; i++) begin
      run_to_req("sp_c");
      ack(1'b0);
    end
    chk("alive8", int'(Alive_cnt), 8);

    Frame_tick = 1'b1;
    repeat (30) step();
    Frame_tick = 1'b0;
    chk("cap_cnt", cnt(), 0);
    chk("cap_state", st(), int'(WAIT));
    chk("cap_valid", int'(sif.Spawn_valid), 0);
    sif.Spawn_ack = 1'b1;
    step();
    sif.Spawn_ack = 1'b0;
    chk("stray_ack", int'(Alive_cnt), 8);

    Zombie_died = 1'b1;
    step();
    Zombie_died = 1'b0;
    chk("free_alive", int'(Alive_cnt), 7);
    chk("free_state", st(), int'(DRAW_X));
    step();
    chk("free_v1", int'(sif.Spawn_valid), 0);
    step();
    chk("free_v2", int'(sif.Spawn_valid), 1);

    Enable = 1'b0;
    repeat (3) step();
    chk("en0_req", int'(sif.Spawn_valid), 1);
    Enable = 1'b1;
    ack(1'b0);
    chk("ack8_cnt", cnt(), 16);
    chk("ack8_alive", int'(Alive_cnt), 8);

    Frame_tick = 1'b1;
    repeat (6) step();
    chk("wait10", cnt(), 10);
    Enable = 1'b0;
    repeat (5) step();
    Frame_tick = 1'b0;
    chk("frz_cnt", cnt(), 10);
    chk("frz_state", st(), int'(WAIT));

    Reset = 1'b1;
    step();
    Reset  = 1'b0;
    chk("rst2_alive", int'(Alive_cnt), 0);
    chk("rst2_state", st(), int'(IDLE));
    step();
    chk("idle_hold", st(), int'(IDLE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
